// File: rtl/u_ifu_inst_buffer_pkg.sv
// Shared IFU widths plus the instruction-buffer entry layout.
// The guarded defines below act as the shared define header for the IFU.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IFU_BUF_DEPTH
`define IFU_BUF_DEPTH 4
`endif

package u_ifu_inst_buffer_pkg;

  localparam int PC_W    = `PC_WIDTH;
  localparam int INST_W  = `INST_WIDTH;
  localparam int ENTRY_W = PC_W + INST_W + 1;

  // Field order fixes the packed entry as {unalign, pc, inst}.
  typedef struct packed {
    logic              unalign;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ifu_entry_t;

  function automatic ifu_entry_t make_entry(input logic [PC_W-1:0] pc,
                                            input logic [INST_W-1:0] inst,
                                            input logic unalign);
    ifu_entry_t e;
    e.unalign = unalign;
    e.pc      = pc;
    e.inst    = inst;
    return e;
  endfunction

endpackage

// File: rtl/u_ifu_inst_buffer_fifo.sv
// Generic synchronous FIFO with clear; head word is readable in the cycle after its push.
module u_ifu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Guards keep the count pinned within 0..DEPTH regardless of the caller.
  assign push_ok = push && (count != CNT_W'(DEPTH));
  assign pop_ok  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && push_ok) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/u_ifu_inst_buffer.sv
// Fetch-to-decode instruction buffer: flush/stall gating around a small sync FIFO.
module u_ifu_inst_buffer
  import u_ifu_inst_buffer_pkg::*;
#(
  parameter int DEPTH = `IFU_BUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_valid,
  input  logic [`PC_WIDTH-1:0]    fetch_pc,
  input  logic [`INST_WIDTH-1:0]  fetch_inst,
  input  logic                    fetch_unalign,
  input  logic                    bru_flush,
  output logic                    ifu_stall,
  output logic                    dec_valid,
  input  logic                    dec_ready,
  output logic [`PC_WIDTH-1:0]    dec_pc,
  output logic [`INST_WIDTH-1:0]  dec_inst,
  output logic                    dec_unalign,
  output logic [$clog2(DEPTH):0]  buf_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ifu_entry_t wr_entry;
  ifu_entry_t head_entry;
  logic       push;
  logic       pop;

  // A flush wins over both sides of the handshake in the same cycle.
  assign push = fetch_valid && !ifu_stall && !bru_flush;
  assign pop  = dec_valid && dec_ready && !bru_flush;

  assign ifu_stall = (buf_count == CNT_W'(DEPTH));
  assign dec_valid = (buf_count != '0);

  assign wr_entry = make_entry(fetch_pc, fetch_inst, fetch_unalign);

  u_ifu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bru_flush),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head_entry),
    .count   (buf_count)
  );

  // Stale storage must never leak to decode while the buffer is empty.
  assign dec_pc      = dec_valid ? head_entry.pc      : '0;
  assign dec_inst    = dec_valid ? head_entry.inst    : '0;
  assign dec_unalign = dec_valid ? head_entry.unalign : 1'b0;

endmodule

// File: tb/tb_u_ifu_inst_buffer.sv
// Directed bench for u_ifu_inst_buffer: queue-based reference model checked every cycle.
module tb_u_ifu_inst_buffer;
  import u_ifu_inst_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_valid;
  logic [PC_W-1:0]   fetch_pc;
  logic [INST_W-1:0] fetch_inst;
  logic              fetch_unalign;
  logic              bru_flush;
  logic              ifu_stall;
  logic              dec_valid;
  logic              dec_ready;
  logic [PC_W-1:0]   dec_pc;
  logic [INST_W-1:0] dec_inst;
  logic              dec_unalign;
  logic [CNT_W-1:0]  buf_count;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              unalign;
  } model_entry_t;

  model_entry_t model_q[$];

  u_ifu_inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_inst    (fetch_inst),
    .fetch_unalign (fetch_unalign),
    .bru_flush     (bru_flush),
    .ifu_stall     (ifu_stall),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_pc        (dec_pc),
    .dec_inst      (dec_inst),
    .dec_unalign   (dec_unalign),
    .buf_count     (buf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] inst_of(input logic [PC_W-1:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Reference model: a plain queue updated from the rules of the buffer.
  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    model_entry_t e;
    if (!rst_n || bru_flush) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() != 0) && dec_ready;
      do_push = fetch_valid && (model_q.size() < DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.pc = fetch_pc; e.inst = fetch_inst; e.unalign = fetch_unalign;
        model_q.push_back(e);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      int n;
      n = model_q.size();
      chk("cyc_count",   64'(buf_count),   64'(n));
      chk("cyc_valid",   64'(dec_valid),   64'(n != 0));
      chk("cyc_stall",   64'(ifu_stall),   64'(n == DEPTH));
      chk("cyc_pc",      64'(dec_pc),      (n != 0) ? 64'(model_q[0].pc) : 64'd0);
      chk("cyc_inst",    64'(dec_inst),    (n != 0) ? 64'(model_q[0].inst) : 64'd0);
      chk("cyc_unalign", 64'(dec_unalign), (n != 0) ? 64'(model_q[0].unalign) : 64'd0);
    end
  end

  task automatic drive(input bit rst, input bit fv, input logic [PC_W-1:0] pc,
                       input bit un, input bit fl, input bit rdy);
    rst_n = rst; fetch_valid = fv; fetch_pc = pc; fetch_inst = inst_of(pc);
    fetch_unalign = un; bru_flush = fl; dec_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic show(input string tag);
    $display("%-10s t=%0t count=%0d valid=%0b stall=%0b pc=%0h unalign=%0b",
             tag, $time, buf_count, dec_valid, ifu_stall, dec_pc, dec_unalign);
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_en = 1'b1;
    drive(1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b1);
    show("reset");
    chk("rst_count", 64'(buf_count), 64'd0);
    chk("rst_valid", 64'(dec_valid), 64'd0);
    chk("rst_stall", 64'(ifu_stall), 64'd0);
    chk("rst_pc",    64'(dec_pc),    64'd0);

    // Fill to full; a fifth push is dropped.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, PC_W'(32'h10 + 4 * i), 1'b0, 1'b0, 1'b0);
      show("fill");
    end
    chk("fill_count", 64'(buf_count), 64'd4);
    chk("fill_stall", 64'(ifu_stall), 64'd1);
    drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    show("fill_drop");
    chk("drop_count", 64'(buf_count), 64'd4);
    chk("drop_head",  64'(dec_pc),    64'h10);

    // Drain; the push offered in the first full+pop cycle stays blocked.
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(dec_pc), 64'(32'h10 + 4 * i));
      drive(1'b1, (i == 0), 32'h20, 1'b0, 1'b0, 1'b1);
      show("drain");
      if (i == 0) begin
        chk("full_pop_count", 64'(buf_count), 64'd3);
        chk("full_pop_stall", 64'(ifu_stall), 64'd0);
      end
    end
    chk("drain_valid", 64'(dec_valid), 64'd0);
    chk("drain_pc0",   64'(dec_pc),    64'd0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("empty_pop", 64'(buf_count), 64'd0);

    // Streaming at occupancy 1 across two pointer wraps.
    drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("stream_pc", 64'(dec_pc), 64'(32'h100 + 4 * i));
      drive(1'b1, 1'b1, PC_W'(32'h104 + 4 * i), 1'b0, 1'b0, 1'b1);
      show("stream");
      chk("stream_count", 64'(buf_count), 64'd1);
    end
    chk("stream_head", 64'(dec_pc), 64'h128);

    // Flush at count 3 with push and pop requested.
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(buf_count), 64'd3);
    drive(1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
    show("flush");
    chk("flush_count", 64'(buf_count), 64'd0);
    chk("flush_valid", 64'(dec_valid), 64'd0);
    drive(1'b1, 1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    show("post_flush");
    chk("post_flush_pc", 64'(dec_pc), 64'h304);

    // Reset mid-operation at count 2.
    drive(1'b1, 1'b1, 32'h308, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(buf_count), 64'd2);
    drive(1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b1);
    show("mid_reset");
    chk("mrst_count", 64'(buf_count), 64'd0);
    chk("mrst_valid", 64'(dec_valid), 64'd0);
    chk("mrst_inst",  64'(dec_inst),  64'd0);
    drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    show("post_rst");
    chk("post_rst_pc", 64'(dec_pc), 64'h40);

    // Unalign flag travels with its entry to the head.
    drive(1'b1, 1'b1, 32'h41, 1'b1, 1'b0, 1'b0);
    chk("unalign_behind", 64'(dec_unalign), 64'd0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    show("unalign");
    chk("unalign_pc",   64'(dec_pc),      64'h41);
    chk("unalign_flag", 64'(dec_unalign), 64'd1);

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/u_ifu_inst_buffer.md
U_IFU_INST_BUFFER -- requirements
Module: u_ifu_inst_buffer

Interface
REQ-001 SHALL take parameter DEPTH, default 4, meaning number of buffer entries; power of two, at least 2.
REQ-002 SHALL take ports clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL take ports rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL take ports fetch_valid, input, 1, IMem read data for fetch_pc is valid this cycle.
REQ-005 SHALL take ports fetch_pc, input, `PC_WIDTH, PC of the fetched instruction.
REQ-006 SHALL take ports fetch_inst, input, `INST_WIDTH, instruction word from IMem rd_data_1.
REQ-007 SHALL take ports fetch_unalign, input, 1, is_pc_unalign flag carried with the entry.
REQ-008 SHALL take ports bru_flush, input, 1, branch redirect; discards all buffered entries.
REQ-009 SHALL take ports ifu_stall, output, 1, buffer full; PC generator holds PC.
REQ-010 SHALL take ports dec_valid, output, 1, head entry valid to decode.
REQ-011 SHALL take ports dec_ready, input, 1, decode accepts head entry this cycle.
REQ-012 SHALL take ports dec_pc / dec_inst / dec_unalign, output, `PC_WIDTH / `INST_WIDTH / 1, head entry fields.
REQ-013 SHALL take ports buf_count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-014 SHALL perform push = fetch_valid & ~ifu_stall & ~bru_flush, writing {pc, inst, unalign} at the write pointer.
REQ-015 SHALL perform pop = dec_valid & dec_ready & ~bru_flush, advancing the read pointer.
REQ-016 SHALL drive ifu_stall = (buf_count == DEPTH), combinational from registered count; push while full is dropped, and upstream is responsible for holding.
REQ-017 SHALL, on push and pop in the same cycle, keep count unchanged and move both pointers; legal at any occupancy below DEPTH.
REQ-018 SHALL, when full with pop asserted, still block the push that cycle; ifu_stall deasserts the following cycle.
REQ-019 SHALL drive dec_valid = (buf_count != 0); when empty, dec_pc, dec_inst and dec_unalign are 0.
REQ-020 SHALL deliver zero-latency head data: an entry pushed at edge N is visible on dec_* after edge N; no fall-through in the push cycle itself.
REQ-021 SHALL wrap pointers modulo DEPTH; each pointer is $clog2(DEPTH) bits and count saturates logically at DEPTH and 0.
REQ-022 SHALL, on bru_flush, zero count and both pointers at the next edge, ignoring same-cycle push and pop; dec_valid is 0 the cycle after flush.
REQ-023 SHALL, on a push the cycle after flush, accept normally; the flush has no residual effect.
REQ-024 SHALL, on pop when empty, do nothing, since dec_valid is 0.
REQ-025 SHALL keep entry storage data unreset; only pointers and count are reset.

Reset
REQ-026 SHALL, with rst_n low at a rising edge, zero count, read and write pointers, giving dec_valid=0, ifu_stall=0, buf_count=0 and dec_* = 0.
REQ-027 SHALL give reset priority over flush, push and pop, and reset mid-operation discards all entries exactly as flush does.
REQ-028 SHALL apply no asynchronous path from rst_n to any output.

Structure
REQ-029 SHALL take `PC_WIDTH and `INST_WIDTH from the shared define header, and add `IFU_BUF_DEPTH (4) there as the top-level DEPTH source.
REQ-030 SHALL place entry storage plus pointers in one sub-module, u_ifu_sync_fifo (parameterised width/depth, push/pop/clear), with flush/stall gating in the top.
REQ-031 SHALL form entry width as `PC_WIDTH + `INST_WIDTH + 1, packed {unalign, pc, inst}.

Verification
REQ-032 SHALL cover Fill: four pushes of pc 0x10/0x14/0x18/0x1C with dec_ready=0 -> buf_count=4, ifu_stall=1, and a fifth push of 0x20 dropped.
REQ-033 SHALL cover Drain: from full, with dec_ready=1 for 4 cycles -> dec_pc sequence 0x10,0x14,0x18,0x1C, then dec_valid=0 and dec_pc=0.
REQ-034 SHALL cover Streaming: push and pop every cycle for 10 cycles starting at count 1 -> count stays 1, pointers wrap twice, and order is preserved.
REQ-035 SHALL cover Flush: at count 3, assert bru_flush with fetch_valid=1 and dec_ready=1 -> next cycle count=0, dec_valid=0, and the flushed-cycle push is absent.
REQ-036 SHALL cover Reset mid-operation: at count 2, drive rst_n low one edge -> all outputs are at reset values, and the following push of pc 0x40 appears as head.
REQ-037 SHALL cover Unalign carry: push pc 0x41 with fetch_unalign=1 -> dec_unalign=1 with dec_pc=0x41 when it reaches the head.
